// File: rtl/serial_tx_arbiter.sv
// -----------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares a single serial_tx_byte transmitter among NUM_REQ packet sources.
// Each source offers one byte at a time on its own lane together with a "last"
// flag. A round-robin arbiter picks an owner, and the grant stays with that
// owner until its last byte has been fully shifted out by the transmitter.
// Every byte goes through the transmitter's send/busy handshake. If busy does
// not rise within ACK_TIMEOUT cycles of a send, the packet is dropped and err
// pulses for one cycle.
//
// Ports
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_req_valid    [NUM_REQ]    lane i holds a byte
//   i_req_data     [8*NUM_REQ]  lane i byte is bits [8i+7:8i]
//   i_req_last     [NUM_REQ]    lane i byte is the last of its packet
//   o_req_ready    [NUM_REQ]    one-hot, combinational; lane byte taken this cycle
//   i_hold         blocks new packet grants while high
//   o_grant        [REQ_BITS]   current owner index
//   o_grant_valid  a packet is in progress
//   o_tx_send      registered send pulse to the transmitter
//   o_tx_data      [8]          registered byte to the transmitter
//   o_tx_block     registered block input of the transmitter
//   i_tx_busy      busy output of the transmitter
//   o_err          one-cycle pulse on send acknowledgement timeout
// -----------------------------------------------------------------------------
module serial_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  localparam int REQ_BITS   = $clog2(NUM_REQ),
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [8*NUM_REQ-1:0]  i_req_data,
  input  logic [NUM_REQ-1:0]    i_req_last,
  output logic [NUM_REQ-1:0]    o_req_ready,
  input  logic                  i_hold,
  output logic [REQ_BITS-1:0]   o_grant,
  output logic                  o_grant_valid,
  output logic                  o_tx_send,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_block,
  input  logic                  i_tx_busy,
  output logic                  o_err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_FETCH     = 2'd1;
  localparam logic [1:0] S_WAIT_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT_DONE = 2'd3;

  // The counter value at which busy has failed to rise in time. Checking one
  // below ACK_TIMEOUT puts the err pulse exactly ACK_TIMEOUT cycles after the
  // send pulse.
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  logic [1:0]          r_state;
  logic [REQ_BITS-1:0] r_grant;
  logic                r_grant_valid;
  logic [REQ_BITS-1:0] r_ptr;
  logic [3:0]          r_cnt;
  logic                r_last;
  logic                r_tx_send;
  logic [7:0]          r_tx_data;
  logic                r_tx_block;
  logic                r_err;

  logic                w_found;
  logic [REQ_BITS-1:0] w_next_owner;
  int                  w_dist;
  int                  w_best;
  logic                w_sel_valid;
  logic                w_sel_last;
  logic [7:0]          w_sel_data;

  // Round-robin pick: each requesting lane gets its distance from ptr+1
  // (modulo NUM_REQ) and the closest one wins. With ptr = NUM_REQ-1, lane 0
  // has distance 0 and is served first.
  always_comb begin
    w_found      = 1'b0;
    w_next_owner = '0;
    w_best       = NUM_REQ;
    w_dist       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(r_ptr) - 1;
      if (w_dist < 0) begin
        w_dist = w_dist + NUM_REQ;
      end
      if (i_req_valid[i] && (w_dist < w_best)) begin
        w_best       = w_dist;
        w_next_owner = REQ_BITS'(i);
        w_found      = 1'b1;
      end
    end
  end

  // Mux the owner's lane out of the packed request buses.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (REQ_BITS'(i) == r_grant) begin
        w_sel_valid = i_req_valid[i];
        w_sel_last  = i_req_last[i];
        w_sel_data  = i_req_data[8*i +: 8];
      end
    end
  end

  // A byte is taken only in FETCH and only from the owner's lane, so ready is
  // at most one-hot by construction.
  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      o_req_ready[i] = (r_state == S_FETCH) && (REQ_BITS'(i) == r_grant) &&
                       i_req_valid[i];
    end
  end

  // Main sequencer. tx_send and err default low each cycle so they are
  // single-cycle pulses. tx_block can only be high after a cycle spent idling
  // in IDLE, so it is never high together with grant_valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_ptr         <= REQ_BITS'(NUM_REQ - 1);
      r_cnt         <= 4'd0;
      r_last        <= 1'b0;
      r_tx_send     <= 1'b0;
      r_tx_data     <= 8'h00;
      r_tx_block    <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_tx_send  <= 1'b0;
      r_err      <= 1'b0;
      r_tx_block <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_hold && w_found) begin
            r_grant       <= w_next_owner;
            r_grant_valid <= 1'b1;
            r_state       <= S_FETCH;
          end else begin
            r_tx_block <= i_hold;
          end
        end
        S_FETCH: begin
          // A gap in the owner's stream just waits here. The grant is kept
          // and no timeout applies.
          if (w_sel_valid) begin
            r_tx_data <= w_sel_data;
            r_last    <= w_sel_last;
            r_tx_send <= 1'b1;
            r_cnt     <= 4'd0;
            r_state   <= S_WAIT_ACK;
          end
        end
        S_WAIT_ACK: begin
          if (i_tx_busy) begin
            r_cnt   <= 4'd0;
            r_state <= S_WAIT_DONE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            r_err         <= 1'b1;
            r_cnt         <= 4'd0;
            r_ptr         <= r_grant;
            r_grant_valid <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_WAIT_DONE: begin
          if (!i_tx_busy) begin
            if (r_last) begin
              r_ptr         <= r_grant;
              r_grant_valid <= 1'b0;
              r_state       <= S_IDLE;
            end else begin
              r_state <= S_FETCH;
            end
          end
        end
        default: begin
          r_grant_valid <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = r_grant_valid;
  assign o_tx_send     = r_tx_send;
  assign o_tx_data     = r_tx_data;
  assign o_tx_block    = r_tx_block;
  assign o_err         = r_err;

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one `serial_tx_byte` transmitter among NUM_REQ requesters. Each requester supplies a packet as a byte stream with a last flag.
- Round-robin arbitration picks an owner. The grant is locked until that owner's last byte has been fully transmitted.
- Sequences the transmitter's send/busy handshake byte by byte, with a timeout on send acknowledgement.
- Sits between the UART packet sources (debug/telemetry) and the single `serial_tx_byte` instance.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- REQ_BITS, $clog2(NUM_REQ): width of the grant index (derived, not overridden).
- ACK_TIMEOUT, 4: cycles allowed after tx_send for tx_busy to rise, range 2..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_REQ  requester i has a byte on its lane
- req_data  in  8*NUM_REQ  byte lane i is bits [8i+7:8i]
- req_last  in  NUM_REQ  current byte on lane i is the last of its packet
- req_ready  out  NUM_REQ  one-hot, combinational; the byte on the lane is consumed this cycle
- hold  in  1  when high, no new packet is granted
- grant  out  REQ_BITS  current owner index
- grant_valid  out  1  a packet is in progress
- tx_send  out  1  send pulse to the transmitter (registered)
- tx_data  out  8  byte to the transmitter (registered)
- tx_block  out  1  block input of the transmitter (registered)
- tx_busy  in  1  busy output of the transmitter
- err  out  1  one-cycle pulse on acknowledgement timeout

Behaviour:
- Reset values (asynchronous on rst_n low, all registered state):
  - state = IDLE; grant = 0; grant_valid = 0.
  - tx_send = 0; tx_data = 8'h00; tx_block = 0; err = 0.
  - RR pointer ptr = NUM_REQ-1; timeout counter = 0.
- Reset mid-packet abandons the packet. tx_send drops immediately and no req_ready is issued after reset.
- States: IDLE, FETCH, WAIT_ACK, WAIT_DONE.
- IDLE:
  - grant_valid = 0; tx_block = hold.
  - If hold = 0 and any req_valid: owner = first i with req_valid[i], scanning ptr+1, ptr+2, ... modulo NUM_REQ.
  - Latch the owner into grant, set grant_valid = 1, go to FETCH.
  - With no request or hold = 1, stay in IDLE.
- FETCH:
  - If req_valid[grant] = 1: req_ready[grant] = 1 this cycle.
  - In the same cycle, capture tx_data <= lane byte and last_q <= req_last[grant].
  - Next cycle tx_send = 1 for exactly one cycle; go to WAIT_ACK.
  - If req_valid[grant] = 0 (gap mid-packet): wait in FETCH with no timeout. The grant is not released.
- WAIT_ACK:
  - Counter increments each cycle. When tx_busy = 1, clear the counter and go to WAIT_DONE.
  - If the counter reaches ACK_TIMEOUT with tx_busy still 0: pulse err for one cycle, set ptr = grant, go to IDLE. The remainder of the packet is abandoned.
- WAIT_DONE:
  - Wait for tx_busy = 0.
  - Then, if last_q = 1: ptr = grant, go to IDLE. Otherwise go to FETCH.
- req_ready is zero in every state except FETCH. At most one bit is ever set.
- tx_block:
  - Never asserted while grant_valid = 1, so hold cannot stall a packet mid-stream.
  - Asserted in IDLE while hold = 1.
- Simultaneous events:
  - A requester asserting while another owns the grant waits; no preemption.
  - hold rising in the same IDLE cycle as a request blocks that grant.
- Wrap-around: the scan index wraps modulo NUM_REQ. With ptr = NUM_REQ-1, index 0 is scanned first.
- Minimum per-byte overhead beyond the transmitter frame: FETCH (1 cycle) + send (1 cycle) + busy rise (1 cycle) + busy fall detect (1 cycle).

Test Plan:
- Transmitter model: busy rises the cycle after send, 10*CLK_PER_BIT cycles per byte.
- Single packet: req 2 sends 8'hA5, 8'h3C, 8'h7E (last on 8'h7E) → grant = 2; tx_data sequence A5, 3C, 7E; three req_ready[2] pulses; grant_valid drops after the final busy fall.
- Contention after reset: req 0–3 all valid, 1-byte packets → grant order 0, 1, 2, 3. Re-asserting all gives 0, 1, 2, 3 again.
- Packet lock: req 0 is mid-packet when req 1 asserts → req 1 is granted only after req 0's last byte completes; no req_ready[1] before that.
- Valid gap: owner drops req_valid for 20 cycles between bytes → stays in FETCH, grant held, err = 0, no tx_send until valid returns.
- Hold: hold = 1 with req 3 valid in IDLE → tx_block = 1, no grant. Release hold → grant = 3 within one cycle.
- Timeout and reset:
  - Tie tx_busy = 0 → err pulses once ACK_TIMEOUT cycles after tx_send; state returns to IDLE.
  - Separately, assert rst_n low during WAIT_DONE → all outputs reach reset values without waiting for a clock edge.
